imem_ctrl: RTL

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl_if.sv | 38 +++
 rtl/imem_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/imem_ctrl_if.sv
// Fetch and program-load bus of the instruction memory controller.
// With IMEM_PARITY_EN defined, if_fault widens to 3 bits (bit2 = parity error).
interface imem_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 10
);
`ifdef IMEM_PARITY_EN
    localparam int FW = 3;
`else
    localparam int FW = 2;
`endif

    // Handshake: a fetch is taken on a rising edge where if_req && if_ready;
    // its result appears with if_valid for exactly the next cycle. A load is
    // written on a rising edge where ld_we && ld_ready. Neither side waits on
    // the other, so one fetch and one load can be taken every cycle.
    logic            if_req;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [FW-1:0]   if_fault;
    logic            ld_we;
    logic [AW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            dbg_state;

    modport master (
        output if_req, if_pc, ld_we, ld_addr, ld_data,
        input  if_ready, if_valid, if_inst, if_fault, ld_ready, dbg_state
    );

    modport slave (
        input  if_req, if_pc, ld_we, ld_addr, ld_data,
        output if_ready, if_valid, if_inst, if_fault, ld_ready, dbg_state
    );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction memory controller: zero-clears the array after reset, then serves
// 1-cycle fetches and program-load writes. Optional parity via IMEM_PARITY_EN.
module imem_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 1024,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int FW = 3;
`else
    localparam int FW = 2;
`endif

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic            w_ready;
    logic            w_clr_we;

    logic [XLEN-1:0] r_mem [DEPTH];
`ifdef IMEM_PARITY_EN
    logic            r_par [DEPTH];
    logic            w_rd_par;
    logic            w_par_err;
`endif

    logic            w_fetch;
    logic            w_load;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_wr_data;
    logic [AW-1:0]   w_rd_idx;
    logic            w_rd_en;
    logic [XLEN-1:0] w_rd_word;
    logic            w_mis;
    logic            w_oor;
    logic [FW-1:0]   w_fault_nxt;
    logic [XLEN-1:0] w_inst_nxt;

    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [FW-1:0]   r_fault;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + AW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_idx == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_ready = 1'b1;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    assign bus.if_ready  = w_ready;
    assign bus.ld_ready  = w_ready;
    assign bus.dbg_state = r_state;

    // ---------------- write port: clear sweep or program load ----------------
    assign w_fetch   = bus.if_req && w_ready;
    assign w_load    = bus.ld_we && w_ready;
    assign w_wr_en   = w_clr_we || w_load;
    assign w_wr_addr = w_clr_we ? r_clr_idx : bus.ld_addr;
    assign w_wr_data = w_clr_we ? '0 : bus.ld_data;

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
`ifdef IMEM_PARITY_EN
            r_par[w_wr_addr] <= ^w_wr_data;
`endif
        end
    end

    // ---------------- fetch path ----------------
    // Upper PC bits beyond the array span mark an out-of-range fetch.
    assign w_rd_idx = bus.if_pc[AW+1:2];
    assign w_mis    = |bus.if_pc[1:0];
    assign w_oor    = |(bus.if_pc >> (AW + 2));
    assign w_rd_en  = w_fetch && !w_mis && !w_oor;

    always_comb begin
        w_rd_word = '0;
`ifdef IMEM_PARITY_EN
        w_rd_par  = 1'b0;
`endif
        if (w_rd_en) begin
            w_rd_word = r_mem[w_rd_idx];
`ifdef IMEM_PARITY_EN
            w_rd_par  = r_par[w_rd_idx];
`endif
        end
    end

`ifdef IMEM_PARITY_EN
    assign w_par_err   = w_rd_en && (^{w_rd_word, w_rd_par});
    assign w_fault_nxt = {w_par_err, w_oor, w_mis};
`else
    assign w_fault_nxt = {w_oor, w_mis};
`endif
    assign w_inst_nxt = (|w_fault_nxt) ? NOP_INST : w_rd_word;

    // Outputs hold their last value between fetches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_fault <= '0;
        end else begin
            r_valid <= w_fetch;
            if (w_fetch) begin
                r_inst  <= w_inst_nxt;
                r_fault <= w_fault_nxt;
            end
        end
    end

    assign bus.if_valid = r_valid;
    assign bus.if_inst  = r_inst;
    assign bus.if_fault = r_fault;
endmodule
